// File: rtl/liveness_monitor.sv
// -----------------------------------------------------------------------------
// liveness_monitor
//
// Watches N_CHAN request/grant channels of the intersection controller and
// flags any request that is not granted within 1..MAX_WAIT cycles. Channels
// marked in PERIODIC behave as if their request were permanently high, so
// they flag any stretch of MAX_WAIT cycles without a grant. Per-channel worst
// served latency and a saturating violation count are kept for debug.
//
// Ports
//   clock        in   single clock, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   enable       in   0 = monitoring off, every channel forced IDLE
//   req          in   [N_CHAN]  per-channel request
//   grant        in   [N_CHAN]  per-channel green indication
//   clear_stats  in   synchronous clear of sticky flags, worst, counters
//   stat_sel     in   channel selected for the stat outputs
//   pending      out  [N_CHAN]  channel is waiting on a grant (FSM state)
//   viol_pulse   out  [N_CHAN]  one-cycle pulse per deadline miss
//   viol_sticky  out  [N_CHAN]  set on a miss, held until clear/reset
//   stat_worst   out  [CNT_W]   worst served latency of channel stat_sel
//   stat_viols   out  [VCNT_W]  violation count of channel stat_sel
// -----------------------------------------------------------------------------
module liveness_monitor #(
  parameter int                N_CHAN   = 4,
  parameter int                MAX_WAIT = 50,
  parameter logic [N_CHAN-1:0] PERIODIC = '0,
  parameter int                VCNT_W   = 8,
  localparam int               CNT_W    = $clog2(MAX_WAIT + 1),
  localparam int               SEL_W    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_CHAN-1:0] req,
  input  logic [N_CHAN-1:0] grant,
  input  logic              clear_stats,
  input  logic [SEL_W-1:0]  stat_sel,
  output logic [N_CHAN-1:0] pending,
  output logic [N_CHAN-1:0] viol_pulse,
  output logic [N_CHAN-1:0] viol_sticky,
  output logic [CNT_W-1:0]  stat_worst,
  output logic [VCNT_W-1:0] stat_viols
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WAIT);
  localparam logic [VCNT_W-1:0] VIOL_MAX = '1;

  state_t            state_q [N_CHAN];
  logic [CNT_W-1:0]  cnt_q   [N_CHAN];   // cycles since the arming request
  logic [CNT_W-1:0]  worst_q [N_CHAN];
  logic [VCNT_W-1:0] viols_q [N_CHAN];
  logic [N_CHAN-1:0] pulse_q;
  logic [N_CHAN-1:0] sticky_q;
  logic [N_CHAN-1:0] r_eff;

  assign r_eff = req | PERIODIC;

  // One FSM per channel. Later non-blocking assignments override the
  // clear_stats defaults, so a miss or a served grant in the clearing cycle
  // lands on freshly cleared stats (miss wins: sticky=1, viols=1).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHAN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        worst_q[i] <= '0;
        viols_q[i] <= '0;
      end
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (clear_stats) begin
          worst_q[i]  <= '0;
          viols_q[i]  <= '0;
          sticky_q[i] <= 1'b0;
        end
        if (!enable) begin
          state_q[i] <= IDLE;
          cnt_q[i]   <= '0;
          pulse_q[i] <= 1'b0;
        end else begin
          pulse_q[i] <= 1'b0;
          if (state_q[i] == IDLE) begin
            // A grant in the arming cycle is ignored: deadline is ##[1:MAX_WAIT].
            if (r_eff[i]) begin
              state_q[i] <= PENDING;
              cnt_q[i]   <= CNT_W'(1);
            end
          end else if (grant[i]) begin
            if (clear_stats || (cnt_q[i] > worst_q[i])) worst_q[i] <= cnt_q[i];
            if (r_eff[i]) begin
              cnt_q[i] <= CNT_W'(1);
            end else begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end
          end else if (cnt_q[i] == MAX_CNT) begin
            pulse_q[i]  <= 1'b1;
            sticky_q[i] <= 1'b1;
            if (clear_stats)                viols_q[i] <= VCNT_W'(1);
            else if (viols_q[i] != VIOL_MAX) viols_q[i] <= viols_q[i] + VCNT_W'(1);
            if (r_eff[i]) begin
              cnt_q[i] <= CNT_W'(1);
            end else begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end
          end else begin
            // Requests arriving here merge into the oldest deadline.
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_CHAN; i++) pending[i] = (state_q[i] == PENDING);
  end

  assign viol_pulse  = pulse_q;
  assign viol_sticky = sticky_q;

  // Out-of-range selects fall through to zero.
  always_comb begin
    stat_worst = '0;
    stat_viols = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (int'(stat_sel) == i) begin
        stat_worst = worst_q[i];
        stat_viols = viols_q[i];
      end
    end
  end

endmodule

// File: tb/tb_liveness_monitor.sv
// -----------------------------------------------------------------------------
// tb_liveness_monitor
//
// Directed scenarios plus a randomized phase for liveness_monitor with
// N_CHAN=4, MAX_WAIT=8, PERIODIC=4'b1100, VCNT_W=4. The reference model keeps,
// per channel, whether a request is outstanding and the cycle number at which
// it was armed; latency is the difference in cycle numbers.
// -----------------------------------------------------------------------------
module tb_liveness_monitor;

  localparam int              N   = 4;
  localparam int              MW  = 8;
  localparam int              VW  = 4;
  localparam int              CW  = 4;
  localparam logic [N-1:0]    PER = 4'b1100;
  localparam int              VSAT = 15;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant = '0;
  logic          clear_stats = 1'b0;
  logic [1:0]    stat_sel = '0;
  logic [N-1:0]  pending;
  logic [N-1:0]  viol_pulse;
  logic [N-1:0]  viol_sticky;
  logic [CW-1:0] stat_worst;
  logic [VW-1:0] stat_viols;

  always #5 clock = ~clock;

  liveness_monitor #(
    .N_CHAN   (N),
    .MAX_WAIT (MW),
    .PERIODIC (PER),
    .VCNT_W   (VW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .clear_stats (clear_stats),
    .stat_sel    (stat_sel),
    .pending     (pending),
    .viol_pulse  (viol_pulse),
    .viol_sticky (viol_sticky),
    .stat_worst  (stat_worst),
    .stat_viols  (stat_viols)
  );

  // ---------------- reference model ----------------
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         m_armed  [N];
  int         m_arm_t  [N];
  int         m_worst  [N];
  int         m_viols  [N];
  bit         m_sticky [N];
  logic [N-1:0] exp_q[$];   // expected viol_pulse per cycle

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_armed[i]  = 0;
      m_arm_t[i]  = 0;
      m_worst[i]  = 0;
      m_viols[i]  = 0;
      m_sticky[i] = 0;
    end
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_edge();
    logic [N-1:0] pv;
    int           age;
    logic         r;
    pv = '0;
    for (int i = 0; i < N; i++) begin
      if (clear_stats) begin
        m_worst[i]  = 0;
        m_viols[i]  = 0;
        m_sticky[i] = 0;
      end
      if (!enable) begin
        m_armed[i] = 0;
        continue;
      end
      r = req[i] | PER[i];
      if (!m_armed[i]) begin
        if (r) begin
          m_armed[i] = 1;
          m_arm_t[i] = cyc;
        end
      end else begin
        age = cyc - m_arm_t[i];
        if (grant[i]) begin
          if (age > m_worst[i]) m_worst[i] = age;
          if (r) m_arm_t[i] = cyc;
          else   m_armed[i] = 0;
        end else if (age >= MW) begin
          pv[i]       = 1'b1;
          m_sticky[i] = 1;
          if (m_viols[i] < VSAT) m_viols[i] = m_viols[i] + 1;
          if (r) m_arm_t[i] = cyc;
          else   m_armed[i] = 0;
        end
      end
    end
    exp_q.push_back(pv);
    cyc++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ep;
    logic [N-1:0] es;
    logic [N-1:0] epulse;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_armed[i];
      es[i] = m_sticky[i];
    end
    epulse = exp_q.pop_front();
    check("pending", 32'(pending), 32'(ep));
    check("viol_pulse", 32'(viol_pulse), 32'(epulse));
    check("viol_sticky", 32'(viol_sticky), 32'(es));
    check("stat_worst", 32'(stat_worst), 32'(m_worst[stat_sel]));
    check("stat_viols", 32'(stat_viols), 32'(m_viols[stat_sel]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] g, input logic clr);
    req         = r;
    grant       = g;
    clear_stats = clr;
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
    req         = '0;
    grant       = '0;
    clear_stats = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  // Watchdog: the stimulus is a fixed number of clock steps.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    model_reset();

    // Reset state
    #3;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_pulse", 32'(viol_pulse), 32'h0);
    check("rst_sticky", 32'(viol_sticky), 32'h0);
    check("rst_worst", 32'(stat_worst), 32'h0);
    check("rst_viols", 32'(stat_viols), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    // 1: request on ch0 served at exactly the deadline
    stat_sel = 2'd0;
    step(4'b0001, '0, 1'b0);
    idle(7);
    step('0, 4'b0001, 1'b0);
    check("t1_pending0", 32'(pending[0]), 32'h0);
    check("t1_pulse0", 32'(viol_pulse[0]), 32'h0);
    check("t1_worst0", 32'(stat_worst), 32'd8);

    // 2: unanswered request on ch1 misses once
    stat_sel = 2'd1;
    step(4'b0010, '0, 1'b0);
    idle(7);
    check("t2_early", 32'(viol_pulse[1]), 32'h0);
    idle(1);
    check("t2_pulse1", 32'(viol_pulse[1]), 32'h1);
    idle(1);
    check("t2_pulse1_once", 32'(viol_pulse[1]), 32'h0);
    check("t2_idle1", 32'(pending[1]), 32'h0);
    check("t2_sticky1", 32'(viol_sticky[1]), 32'h1);
    check("t2_viols1", 32'(stat_viols), 32'd1);

    // 3: same-cycle grant does not serve; grant at +3 does
    stat_sel = 2'd0;
    step('0, '0, 1'b1);
    step(4'b0001, 4'b0001, 1'b0);
    idle(2);
    step('0, 4'b0001, 1'b0);
    check("t3_worst0", 32'(stat_worst), 32'd3);
    check("t3_idle0", 32'(pending[0]), 32'h0);

    // 4: ch2 granted every 8 with one gap of 9; ch3 starved until saturation
    cnt = 0;
    stat_sel = 2'd3;
    for (int s = 0; s < 128; s++) begin
      logic [N-1:0] g;
      g = '0;
      if (s == 0) g = 4'b1100;
      else if ((s <= 64 && s % 8 == 0) || (s >= 73 && (s - 73) % 8 == 0)) g = 4'b0100;
      step('0, g, (s == 0));
      cnt += int'(viol_pulse[2]);
    end
    check("t4_ch2_pulses", 32'(cnt), 32'd1);
    check("t4_viols3_sat", 32'(stat_viols), 32'd15);
    stat_sel = 2'd2;
    #1;
    check("t4_viols2", 32'(stat_viols), 32'd1);

    // 5: asynchronous reset mid-wait, then a disabled window
    stat_sel = 2'd3;
    step(4'b0001, '0, 1'b0);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t5_rst_pending", 32'(pending), 32'h0);
    check("t5_rst_pulse", 32'(viol_pulse), 32'h0);
    check("t5_rst_sticky", 32'(viol_sticky), 32'h0);
    check("t5_rst_viols", 32'(stat_viols), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(10);
    check("t5_no_pulse0", 32'(viol_sticky[0]), 32'h0);
    check("t5_viols3", 32'(stat_viols), 32'd1);
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0011, '0, 1'b0);
      cnt += int'($countones(viol_pulse));
    end
    check("t5_dis_pulses", 32'(cnt), 32'd0);
    check("t5_dis_viols3", 32'(stat_viols), 32'd1);
    check("t5_dis_sticky3", 32'(viol_sticky[3]), 32'h1);
    enable = 1'b1;

    // 6: clear coincident with a miss on ch1, then a clear on its own
    stat_sel = 2'd1;
    step(4'b0010, '0, 1'b0);
    idle(7);
    step('0, '0, 1'b1);
    check("t6_pulse1", 32'(viol_pulse[1]), 32'h1);
    check("t6_sticky1", 32'(viol_sticky[1]), 32'h1);
    check("t6_viols1", 32'(stat_viols), 32'd1);
    step('0, 4'b1100, 1'b0);
    step('0, '0, 1'b1);
    check("t6_clr_sticky", 32'(viol_sticky), 32'h0);
    for (int c = 0; c < N; c++) begin
      stat_sel = 2'(c);
      #1;
      check("t6_clr_worst", 32'(stat_worst), 32'h0);
      check("t6_clr_viols", 32'(stat_viols), 32'h0);
    end

    // Randomized phase against the model
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      logic [N-1:0] g;
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 5) == 0);
        g[i] = ($urandom_range(0, 6) == 0);
      end
      enable   = ($urandom_range(0, 29) != 0);
      stat_sel = 2'($urandom_range(0, 3));
      step(r, g, ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
